// File: rtl/bus_pkg.sv
// Shared bus definitions: master state encoding, frame start bit and default field widths.
package bus_pkg;

  localparam int DEF_ADDRESS_WIDTH  = 12;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_SLAVE_ID_WIDTH = 2;

  localparam logic START_BIT = 1'b1;

  typedef enum logic [3:0] {
    M_IDLE,
    M_REQ,
    M_START,
    M_SID,
    M_ADDR,
    M_WDATA,
    M_ACK,
    M_WBUSY,
    M_RSTART,
    M_RDATA,
    M_DONE,
    M_ABORT
  } master_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// Parallel-load, LSB-first shift register; serial input enters at the MSB so received bits land LSB-first.
module bus_shift_reg #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             shift,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] load_val,
  output logic             ser_out,
  output logic [WIDTH-1:0] par_q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_q <= '0;
    end else if (load) begin
      par_q <= load_val;
    end else if (shift) begin
      par_q <= {ser_in, par_q[WIDTH-1:1]};
    end
  end

  assign ser_out = par_q[0];

endmodule

// File: rtl/bus_master_port.sv
// Serial bus initiator: arbitrates, sends start/slave id/address/write data, completes on slave_busy.
// Optional abort-on-timeout is built when MASTER_TIMEOUT_EN is defined.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int SLAVE_ID_WIDTH = DEF_SLAVE_ID_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [SLAVE_ID_WIDTH-1:0] req_slave,
  input  logic [ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      done,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      error,
  output logic                      bus_req,
  input  logic                      bus_grant,
  output logic                      bus_util,
  output logic                      rd_wrt,
  inout  wire logic                 data_bus_serial,
  input  logic                      slave_busy
);

  localparam int SR_W  = max_int(ADDRESS_WIDTH, DATA_WIDTH);
  localparam int CNT_W = $clog2(SR_W);

  localparam logic [CNT_W-1:0] SID_LAST  = CNT_W'(SLAVE_ID_WIDTH - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDRESS_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  master_state_t state, state_nxt;

  logic                      wr_q;
  logic [SLAVE_ID_WIDTH-1:0] slave_q;
  logic [ADDRESS_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [CNT_W-1:0]          bit_cnt;

  logic            field_last;
  logic            sr_load, sr_shift, sr_out;
  logic [SR_W-1:0] sr_load_val, sr_q;
  logic            sr_unused;
  logic            line_in;
  logic            own_bus, drive_line, tx_bit;
  logic            timeout_hit;

  assign line_in = data_bus_serial;

`ifdef MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            waiting;

  assign waiting = state inside {M_ACK, M_WBUSY, M_RSTART, M_RDATA};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt <= '0;
    end else if (waiting) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign timeout_hit = waiting && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign error       = (state == M_ABORT);
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
  assign error          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= M_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    field_last  = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_load_val = '0;
    case (state)
      M_IDLE:   if (req_valid) state_nxt = M_REQ;
      M_REQ:    if (bus_grant) state_nxt = M_START;
      M_START: begin
        sr_load     = 1'b1;
        sr_load_val = SR_W'(slave_q);
        state_nxt   = M_SID;
      end
      M_SID: begin
        field_last = (bit_cnt == SID_LAST);
        if (field_last) begin
          sr_load     = 1'b1;
          sr_load_val = SR_W'(addr_q);
          state_nxt   = M_ADDR;
        end else begin
          sr_shift = 1'b1;
        end
      end
      M_ADDR: begin
        field_last = (bit_cnt == ADDR_LAST);
        if (field_last && wr_q) begin
          sr_load     = 1'b1;
          sr_load_val = SR_W'(wdata_q);
          state_nxt   = M_WDATA;
        end else if (field_last) begin
          state_nxt = M_ACK;
        end else begin
          sr_shift = 1'b1;
        end
      end
      M_WDATA: begin
        field_last = (bit_cnt == DATA_LAST);
        sr_shift   = 1'b1;
        if (field_last) state_nxt = M_ACK;
      end
      M_ACK:    if (slave_busy) state_nxt = wr_q ? M_WBUSY : M_RSTART;
      M_WBUSY:  if (!slave_busy) state_nxt = M_DONE;
      M_RSTART: if (line_in == START_BIT) state_nxt = M_RDATA;
      M_RDATA: begin
        field_last = (bit_cnt == DATA_LAST);
        sr_shift   = 1'b1;
        if (field_last) state_nxt = M_DONE;
      end
      M_DONE:   state_nxt = M_IDLE;
      M_ABORT:  state_nxt = M_IDLE;
      default:  state_nxt = M_IDLE;
    endcase
    // Abort wins over every wait-state transition, including the final read bit.
    if (timeout_hit) state_nxt = M_ABORT;
  end

  // Any state change is a field entry, so the counter restarts there.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt <= '0;
    end else if (state_nxt != state) begin
      bit_cnt <= '0;
    end else if (state inside {M_SID, M_ADDR, M_WDATA, M_RDATA}) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q    <= 1'b0;
      slave_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == M_IDLE && req_valid) begin
      wr_q    <= req_wr;
      slave_q <= req_slave;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  bus_shift_reg #(
    .WIDTH(SR_W)
  ) u_shift (
    .clk      (clk),
    .rstn     (rstn),
    .load     (sr_load),
    .shift    (sr_shift),
    .ser_in   (line_in),
    .load_val (sr_load_val),
    .ser_out  (sr_out),
    .par_q    (sr_q)
  );

  assign sr_unused = ^sr_q;

  // The last bit is still on the line, so rdata merges it with the bits already shifted in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (state == M_RDATA && state_nxt == M_DONE) begin
      rdata <= {line_in, sr_q[SR_W-1 -: DATA_WIDTH-1]};
    end
  end

  assign req_ready  = (state == M_IDLE);
  assign done       = (state == M_DONE);
  assign bus_req    = !(state inside {M_IDLE, M_ABORT});
  assign own_bus    = state inside {M_START, M_SID, M_ADDR, M_WDATA,
                                    M_ACK, M_WBUSY, M_RSTART, M_RDATA};
  assign drive_line = state inside {M_START, M_SID, M_ADDR, M_WDATA};
  assign tx_bit     = (state == M_START) ? START_BIT : sr_out;

  assign bus_util        = own_bus ? 1'b1 : 1'bz;
  assign rd_wrt          = own_bus ? wr_q : 1'bz;
  assign data_bus_serial = drive_line ? tx_bit : 1'bz;

endmodule
